// File: rtl/sirc_user_port_responder_if.sv
// ---------------------------------------------------------------------------
// sirc_user_port_responder_if
//
// User-circuit side of the SIRC interface: three req/ack handshakes
// (register32 command, input memory read, output memory write) plus the run
// register handshake.
//   master : the user circuit (drives Req/address/data, userRunClear)
//   slave  : the responder    (drives Ack/DataValid/ReadData, userRunValue)
// Widths follow the memory configuration parameters, which must match the
// ones given to the responder.
// ---------------------------------------------------------------------------
interface sirc_user_port_responder_if #(
    parameter int INMEM_BYTE_WIDTH     = 1,
    parameter int OUTMEM_BYTE_WIDTH    = 1,
    parameter int INMEM_ADDRESS_WIDTH  = 8,
    parameter int OUTMEM_ADDRESS_WIDTH = 8
);
    // run register
    logic                              userRunValue;
    logic                              userRunClear;
    // register32 command port
    logic                              register32CmdReq;
    logic                              register32CmdAck;
    logic                              register32WriteEn;
    logic [7:0]                        register32Address;
    logic [31:0]                       register32WriteData;
    logic                              register32ReadDataValid;
    logic [31:0]                       register32ReadData;
    // input memory read port
    logic                              inputMemoryReadReq;
    logic                              inputMemoryReadAck;
    logic [INMEM_ADDRESS_WIDTH-1:0]    inputMemoryReadAdd;
    logic                              inputMemoryReadDataValid;
    logic [INMEM_BYTE_WIDTH*8-1:0]     inputMemoryReadData;
    // output memory write port
    logic                              outputMemoryWriteReq;
    logic                              outputMemoryWriteAck;
    logic [OUTMEM_ADDRESS_WIDTH-1:0]   outputMemoryWriteAdd;
    logic [OUTMEM_BYTE_WIDTH*8-1:0]    outputMemoryWriteData;
    logic [OUTMEM_BYTE_WIDTH-1:0]      outputMemoryWriteByteMask;

    modport master (
        input  userRunValue,
        output userRunClear,
        output register32CmdReq, register32WriteEn, register32Address, register32WriteData,
        input  register32CmdAck, register32ReadDataValid, register32ReadData,
        output inputMemoryReadReq, inputMemoryReadAdd,
        input  inputMemoryReadAck, inputMemoryReadDataValid, inputMemoryReadData,
        output outputMemoryWriteReq, outputMemoryWriteAdd, outputMemoryWriteData,
        output outputMemoryWriteByteMask,
        input  outputMemoryWriteAck
    );

    modport slave (
        output userRunValue,
        input  userRunClear,
        input  register32CmdReq, register32WriteEn, register32Address, register32WriteData,
        output register32CmdAck, register32ReadDataValid, register32ReadData,
        input  inputMemoryReadReq, inputMemoryReadAdd,
        output inputMemoryReadAck, inputMemoryReadDataValid, inputMemoryReadData,
        input  outputMemoryWriteReq, outputMemoryWriteAdd, outputMemoryWriteData,
        input  outputMemoryWriteByteMask,
        output outputMemoryWriteAck
    );
endinterface

// File: rtl/sirc_user_port_responder.sv
// ---------------------------------------------------------------------------
// sirc_user_port_responder
//
// Responder end of the SIRC user-circuit interface. Owns the 32-bit parameter
// register file, the input memory buffer, the output memory buffer and the
// run register, and answers the user circuit's req/ack handshakes.
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous, active-low reset
//   hostRunSet          pulse, sets the run register (wins over userRunClear)
//   hostRegWrite*       host write into the parameter register file
//   hostInMemWrite*     host write into the input memory
//   hostOutMemReadAdd   host read address of the output memory
//   hostOutMemReadData  registered output memory data, 1 cycle after address
//   usr                 user-side handshakes (slave modport)
//
// Configuration macro
//   SIRC_RESP_ACK_STALL_EN : when defined, a free-running toggle gates all
//                            three user Acks so they can only be 1 on
//                            alternate cycles.
// ---------------------------------------------------------------------------
module sirc_user_port_responder #(
    parameter int INMEM_BYTE_WIDTH     = 1,
    parameter int OUTMEM_BYTE_WIDTH    = 1,
    parameter int INMEM_ADDRESS_WIDTH  = 8,
    parameter int OUTMEM_ADDRESS_WIDTH = 8,
    parameter int REG_COUNT            = 8,
    parameter int READ_LATENCY         = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              hostRunSet,
    input  logic                              hostRegWriteEn,
    input  logic [7:0]                        hostRegAddress,
    input  logic [31:0]                       hostRegWriteData,
    input  logic                              hostInMemWriteEn,
    input  logic [INMEM_ADDRESS_WIDTH-1:0]    hostInMemWriteAdd,
    input  logic [INMEM_BYTE_WIDTH*8-1:0]     hostInMemWriteData,
    input  logic [OUTMEM_ADDRESS_WIDTH-1:0]   hostOutMemReadAdd,
    output logic [OUTMEM_BYTE_WIDTH*8-1:0]    hostOutMemReadData,
    sirc_user_port_responder_if.slave         usr
);

    localparam int IW     = INMEM_BYTE_WIDTH * 8;
    localparam int OW     = OUTMEM_BYTE_WIDTH * 8;
    localparam int IDEPTH = 1 << INMEM_ADDRESS_WIDTH;
    localparam int ODEPTH = 1 << OUTMEM_ADDRESS_WIDTH;
    localparam int RIW    = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

    function automatic logic reg_in_range(input logic [7:0] a);
        return {24'd0, a} < 32'(REG_COUNT);
    endfunction

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    logic [31:0]                         regs_q   [REG_COUNT];
    logic [IW-1:0]                       inmem_q  [IDEPTH];
    logic [OUTMEM_BYTE_WIDTH-1:0][7:0]   outmem_q [ODEPTH];
    logic [OW-1:0]                       hostrd_q;
    logic                                run_q, run_d;

    // -----------------------------------------------------------------------
    // Ack generation. Acks are pure combinational functions of the requests;
    // the reset term keeps them low while the block is held in reset.
    // -----------------------------------------------------------------------
    logic ack_gate;

`ifdef SIRC_RESP_ACK_STALL_EN
    logic stall_tog_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stall_tog_q <= 1'b0;
        else        stall_tog_q <= ~stall_tog_q;
    end

    assign ack_gate = stall_tog_q;
`else
    assign ack_gate = 1'b1;
`endif

    logic reg_ack, in_ack, out_ack;
    logic reg_acc, reg_rd_acc, reg_wr_acc, in_acc, out_acc;

    // A host register write owns the register file for that cycle, so the
    // user command is held off; this also rules out a same-address collision.
    assign reg_ack = reset & ack_gate & usr.register32CmdReq & ~hostRegWriteEn;
    // The input memory is single-ported: the host write has priority.
    assign in_ack  = reset & ack_gate & usr.inputMemoryReadReq & ~hostInMemWriteEn;
    assign out_ack = reset & ack_gate & usr.outputMemoryWriteReq;

    assign reg_acc    = usr.register32CmdReq & reg_ack;
    assign reg_rd_acc = reg_acc & ~usr.register32WriteEn;
    assign reg_wr_acc = reg_acc &  usr.register32WriteEn;
    assign in_acc     = usr.inputMemoryReadReq & in_ack;
    assign out_acc    = usr.outputMemoryWriteReq & out_ack;

    // -----------------------------------------------------------------------
    // Parameter register file
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
        end else if (hostRegWriteEn) begin
            if (reg_in_range(hostRegAddress))
                regs_q[hostRegAddress[RIW-1:0]] <= hostRegWriteData;
        end else if (reg_wr_acc && reg_in_range(usr.register32Address)) begin
            regs_q[usr.register32Address[RIW-1:0]] <= usr.register32WriteData;
        end
    end

    logic [31:0] reg_rd_val;
    assign reg_rd_val = reg_in_range(usr.register32Address)
                        ? regs_q[usr.register32Address[RIW-1:0]] : 32'd0;

    // -----------------------------------------------------------------------
    // Read-latency pipelines. Each stage only loads data when its incoming
    // valid is set, so the last stage holds the previous result while idle.
    // -----------------------------------------------------------------------
    logic [READ_LATENCY-1:0] rvld_q, rvld_d;
    logic [31:0]             rdat_q [READ_LATENCY];
    logic [31:0]             rdat_d [READ_LATENCY];
    logic [READ_LATENCY-1:0] ivld_q, ivld_d;
    logic [IW-1:0]           idat_q [READ_LATENCY];
    logic [IW-1:0]           idat_d [READ_LATENCY];

    always_comb begin
        rvld_d = '0;
        ivld_d = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            rdat_d[i] = '0;
            idat_d[i] = '0;
        end
        rvld_d[0] = reg_rd_acc;
        rdat_d[0] = reg_rd_val;
        ivld_d[0] = in_acc;
        idat_d[0] = inmem_q[usr.inputMemoryReadAdd];
        for (int i = 1; i < READ_LATENCY; i++) begin
            rvld_d[i] = rvld_q[i-1];
            rdat_d[i] = rdat_q[i-1];
            ivld_d[i] = ivld_q[i-1];
            idat_d[i] = idat_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvld_q <= '0;
            ivld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                rdat_q[i] <= '0;
                idat_q[i] <= '0;
            end
        end else begin
            rvld_q <= rvld_d;
            ivld_q <= ivld_d;
            for (int i = 0; i < READ_LATENCY; i++) begin
                if (rvld_d[i]) rdat_q[i] <= rdat_d[i];
                if (ivld_d[i]) idat_q[i] <= idat_d[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Memory arrays (contents survive reset)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (hostInMemWriteEn)
            inmem_q[hostInMemWriteAdd] <= hostInMemWriteData;
    end

    always_ff @(posedge clk) begin
        if (out_acc) begin
            for (int b = 0; b < OUTMEM_BYTE_WIDTH; b++) begin
                if (usr.outputMemoryWriteByteMask[b])
                    outmem_q[usr.outputMemoryWriteAdd][b] <= usr.outputMemoryWriteData[8*b +: 8];
            end
        end
    end

    // Host read port: a same-cycle user write is not forwarded, so the old
    // contents are returned.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) hostrd_q <= '0;
        else        hostrd_q <= outmem_q[hostOutMemReadAdd];
    end

    // -----------------------------------------------------------------------
    // Run register: set has priority over clear.
    // -----------------------------------------------------------------------
    always_comb begin
        run_d = run_q;
        if (usr.userRunClear) run_d = 1'b0;
        if (hostRunSet)       run_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) run_q <= 1'b0;
        else        run_q <= run_d;
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign usr.register32CmdAck         = reg_ack;
    assign usr.inputMemoryReadAck       = in_ack;
    assign usr.outputMemoryWriteAck     = out_ack;
    assign usr.register32ReadDataValid  = rvld_q[READ_LATENCY-1];
    assign usr.register32ReadData       = rdat_q[READ_LATENCY-1];
    assign usr.inputMemoryReadDataValid = ivld_q[READ_LATENCY-1];
    assign usr.inputMemoryReadData      = idat_q[READ_LATENCY-1];
    assign usr.userRunValue             = run_q;
    assign hostOutMemReadData           = hostrd_q;

endmodule
